// File: rtl/act_writeback.sv
// act_writeback
//   Consumer end of the activation unit's output interface. Each accepted
//   4-lane x 32-bit activation beat is requantized lane by lane to an
//   unsigned byte (rounding arithmetic right shift, then clamp to 0..255).
//   The four bytes are packed into one 32-bit word and pushed into a small
//   FIFO. The FIFO head is written to sequential unified-buffer addresses.
//   Each start pulse runs one programmed transfer of cfg_len words.
//
// Ports
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   start             one-cycle pulse; latches cfg_* only while idle
//   cfg_base          first unified-buffer write address
//   cfg_len           number of beats/words in the transfer (0 allowed)
//   cfg_shift         requantization right-shift amount
//   dv_acout, acout   activation beat valid / 4 signed 32-bit lanes
//   acout_ready       block can take a beat this cycle
//   ub_wr_en          write request valid (FIFO not empty)
//   ub_wr_ready       unified buffer accepts the write
//   ub_wr_addr        write address
//   ub_wr_data        packed bytes, lane i at [8*i+7:8*i]
//   busy              high while the transfer is running or draining
//   done              one-cycle completion pulse
//   overflow_err      sticky: a beat was offered while acout_ready was low
//
// Handshakes: both interfaces use strict valid/ready. A transfer happens
// on a rising edge where valid && ready. ready never waits for valid. A
// producer holding valid while ready is low keeps its payload stable. On
// the write side this block keeps ub_wr_addr/ub_wr_data stable while
// ub_wr_en is high and ub_wr_ready is low. On the activation side, a beat
// offered while acout_ready is low is dropped and flagged in overflow_err.
module act_writeback #(
  parameter int LANES      = 4,
  parameter int IN_W       = 32,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     cfg_base,
  input  logic [ADDR_W-1:0]     cfg_len,
  input  logic [4:0]            cfg_shift,
  input  logic                  dv_acout,
  input  logic [LANES*IN_W-1:0] acout,
  output logic                  acout_ready,
  output logic                  ub_wr_en,
  input  logic                  ub_wr_ready,
  output logic [ADDR_W-1:0]     ub_wr_addr,
  output logic [LANES*8-1:0]    ub_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]     len_q;
  logic [4:0]            shift_q;
  logic [ADDR_W-1:0]     accepted;

  logic [LANES*8-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  start_ok;
  logic                  push;
  logic                  pop;
  logic [LANES*8-1:0]    packed_word;

  // Rounding right shift then clamp to an unsigned byte. The sum is formed
  // at IN_W+1 bits so adding the rounding constant can never wrap.
  function automatic logic [7:0] requant(input logic [IN_W-1:0] x,
                                         input logic [4:0]      sh);
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] y;
    ext = {x[IN_W-1], x};
    rnd = '0;
    y   = ext;
    if (sh != 5'd0) begin
      rnd = {{IN_W{1'b0}}, 1'b1} << (sh - 5'd1);
      y   = (ext + rnd) >>> sh;
    end
    if (y[IN_W]) begin
      requant = 8'd0;
    end else if (|y[IN_W-1:8]) begin
      requant = 8'hFF;
    end else begin
      requant = y[7:0];
    end
  endfunction

  always_comb begin
    packed_word = '0;
    for (int i = 0; i < LANES; i++) begin
      packed_word[8*i +: 8] = requant(acout[IN_W*i +: IN_W], shift_q);
    end
  end

  // Handshake and FIFO status
  assign fifo_empty  = (fifo_count == '0);
  assign fifo_full   = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign start_ok    = start && (state == S_IDLE);

  // Ready looks only at the registered count; a pop in the same cycle does
  // not open an extra slot. That keeps ready free of the ub_wr_ready path.
  assign acout_ready = (state == S_RUN) && !fifo_full && (accepted < len_q);
  assign push        = dv_acout && acout_ready;
  assign ub_wr_en    = !fifo_empty;
  assign pop         = ub_wr_en && ub_wr_ready;
  // Empty FIFO presents zero so the write data is clean after reset.
  assign ub_wr_data  = fifo_empty ? '0 : fifo_mem[rd_ptr];

  // FSM next state and outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (cfg_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (accepted == len_q) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Leave as the final word is handshaken, not a cycle later.
        if (fifo_empty || ((fifo_count == CNT_W'(1)) && pop)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, configuration, counters and address
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      len_q        <= '0;
      shift_q      <= '0;
      accepted     <= '0;
      ub_wr_addr   <= '0;
      overflow_err <= 1'b0;
    end else begin
      state <= state_nxt;

      if (start_ok) begin
        len_q      <= cfg_len;
        shift_q    <= cfg_shift;
        accepted   <= '0;
        ub_wr_addr <= cfg_base;
      end else begin
        if (push) begin
          accepted <= accepted + ADDR_W'(1);
        end
        if (pop) begin
          ub_wr_addr <= ub_wr_addr + ADDR_W'(1);
        end
      end

      // A fresh start clears the flag even if a stray beat arrives with it.
      if (start_ok) begin
        overflow_err <= 1'b0;
      end else if (dv_acout && !acout_ready) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= packed_word;
    end
  end

endmodule

// File: doc/act_writeback.md
Name: act_writeback

Overview:
Consumer end of the activation unit's output interface. Takes 4-lane x 32-bit activation beats (dv_acout/acout), requantizes each lane to unsigned 8 bits (rounding right shift + saturation), packs the 4 bytes into one 32-bit word, buffers words in a small FIFO, and writes them to sequential unified-buffer addresses over a valid/ready write port. Sits between the activation unit and the unified buffer. Runs one programmed transfer per start pulse.

Parameters:
LANES, 4, activation lanes per beat (fixed at 4 for this revision)
IN_W, 32, bits per input lane
ADDR_W, 8, unified-buffer address width
FIFO_DEPTH, 4, packed-word FIFO entries (power of 2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; latches cfg_* when idle
cfg_base  input  ADDR_W  first write address
cfg_len  input  ADDR_W  number of words (beats) in the transfer
cfg_shift  input  5  right-shift amount for requantization
dv_acout  input  1  activation beat valid
acout  input  128  lane i = acout[32*i+31:32*i], signed two's complement
acout_ready  output  1  block can accept a beat this cycle
ub_wr_en  output  1  write request valid
ub_wr_ready  input  1  unified buffer accepts the write
ub_wr_addr  output  ADDR_W  write address
ub_wr_data  output  32  packed bytes, lane i at [8*i+7:8*i]
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle pulse at transfer completion
overflow_err  output  1  sticky: dv_acout seen while acout_ready low

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, FIFO emptied, counters 0; all outputs 0 (ub_wr_addr=0, ub_wr_data=0, overflow_err=0). Reset mid-transfer aborts it: no further ub_wr_en, no done pulse.
- FSM: IDLE -> RUN on start (cfg latched; overflow_err cleared). If cfg_len=0: IDLE -> DONE instead. RUN -> DRAIN when accepted count reaches len. DRAIN -> DONE when FIFO is empty and the last write has been handshaken. DONE -> IDLE after one cycle; done=1 only in DONE. busy=1 in RUN and DRAIN. start is ignored outside IDLE.
- acout_ready = (state==RUN) && (fifo_count < FIFO_DEPTH) && (accepted < len). Combinational; does not anticipate a same-cycle pop.
- A beat is accepted when dv_acout && acout_ready. If dv_acout && !acout_ready, set overflow_err (sticky until next accepted start); the beat is dropped.
- Requant per lane: x = signed 32-bit lane; if shift>0, y = (x + 2^(shift-1)) >>> shift (arithmetic, computed at 33 bits so no wrap), else y = x. Byte = 0 if y<0, 255 if y>255, else y[7:0].
- Accepted beat is quantized and pushed into the FIFO at that clk edge. FIFO head drives ub_wr_data; ub_wr_en = FIFO not empty. With an empty FIFO, ub_wr_en rises the cycle after acceptance.
- Write handshake: completes on ub_wr_en && ub_wr_ready at clk edge; FIFO pops, ub_wr_addr increments by 1 modulo 2^ADDR_W (0xFF -> 0x00 at ADDR_W=8). ub_wr_addr = cfg_base from the cycle after start. While ub_wr_en=1 and ub_wr_ready=0, ub_wr_addr and ub_wr_data are held stable.
- Simultaneous push and pop: fifo_count unchanged, ordering preserved. Sustained throughput is 1 word/cycle with ub_wr_ready held high.

Test Plan:
1. base=0x10, len=2, shift=0, ub_wr_ready=1; beats lanes{0..3}={11,9,9,11} then {100,1,100,1} -> writes 0x0B09090B @0x10, 0x01640164 @0x11; done pulses once after the second write; busy falls with it.
2. shift=4, lanes {23, 24, 4096, -16} -> bytes {1,2,255,0} -> ub_wr_data 0x00FF0201; shift=0, lane0=300 -> byte 255; lane0=-1 -> byte 0.
3. len=6, beats every cycle, ub_wr_ready=0 for 10 cycles -> acout_ready low after 4 accepts, addr/data held constant, overflow_err=1 if the bench keeps dv_acout high; on release, 6 writes at base..base+5 in order.
4. base=0xFE, len=3 -> addresses 0xFE, 0xFF, 0x00.
5. len=0 -> done pulse the cycle after start, no ub_wr_en; dv_acout while IDLE -> overflow_err=1; next start clears it.
6. len=4, rst asserted after 2 writes -> all outputs 0 next cycle, no further writes or done; a new start with len=1 completes normally.
